data_fifo_flags: RTL and testbench



---
 rtl/comm_pkg.sv | 16 +
 rtl/fifo_mem_sdp.sv | 37 +++
 rtl/data_fifo_flags.sv | 120 ++++++++++++
 tb/tb_data_fifo_flags.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared constants and helpers for the comm-path FIFOs.
package comm_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int ADC_FIFO_DEPTH  = 16;
    localparam int UART_FIFO_DEPTH = 16;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port RAM: one write port, one read port (registered or async).
module fifo_mem_sdp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4,
    parameter int REG_RD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    if (REG_RD != 0) begin : g_reg_rd
        // Output register loads only on a pop and holds otherwise.
        always_ff @(posedge clk) begin
            if (rst)        rd_data <= '0;
            else if (rd_en) rd_data <= mem[rd_addr];
        end
    end else begin : g_async_rd
        logic unused_rd_ctl;
        assign unused_rd_ctl = rst ^ rd_en;
        assign rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/data_fifo_flags.sv
// Synchronous FIFO with level, almost thresholds, sticky errors, flush, FWFT option.
module data_fifo_flags
    import comm_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = clog2(DEPTH),
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PTR_W:0]    level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PTR_W != clog2(DEPTH) ||
        AF_THRESH > DEPTH || AE_THRESH >= DEPTH || AF_THRESH < 0 || AE_THRESH < 0) begin : g_bad_params
        $error("data_fifo_flags: illegal DEPTH/PTR_W/threshold parameters");
    end

    localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AF_L    = (PTR_W+1)'(AF_THRESH);
    localparam logic [PTR_W:0] AE_L    = (PTR_W+1)'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   level_nxt;
    logic             wr_acc, rd_acc;
    logic             ovf_set, udf_set;

    // Accept decisions use pre-edge flags; flush discards both requests.
    assign rd_acc  = rd_en & ~empty & ~flush;
    assign wr_acc  = wr_en & (~full | rd_acc) & ~flush;
    assign ovf_set = wr_en & ~wr_acc & ~flush;
    assign udf_set = rd_en & ~rd_acc & ~flush;

    // Next fill level from the accepted push/pop pair.
    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Pointers, level and registered flags (flags follow next-level so they align with level).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            level        <= level_nxt;
            full         <= (level_nxt == DEPTH_L);
            empty        <= (level_nxt == '0);
            almost_full  <= (level_nxt >= AF_L);
            almost_empty <= (level_nxt <= AE_L);
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (udf_set)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

    fifo_mem_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .REG_RD ((FWFT != 0) ? 0 : 1)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        assign rd_valid = ~empty;
    end else begin : g_regrd
        // One-cycle valid pulse accompanying each popped word.
        always_ff @(posedge clk) begin
            if (rst) rd_valid <= 1'b0;
            else     rd_valid <= rd_acc;
        end
    end

endmodule

// File: tb/tb_data_fifo_flags.sv
// Directed bench: DEPTH=4 registered-read instance and DEPTH=4 FWFT instance.
module tb_data_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Instance A: FWFT=0
    logic       a_rst, a_flush, a_wr_en, a_rd_en, a_err_clr;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_level;

    // Instance B: FWFT=1
    logic       b_rst, b_flush, b_wr_en, b_rd_en, b_err_clr;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_level;

    data_fifo_flags #(.DATA_W(8), .DEPTH(4), .PTR_W(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .level(a_level),
        .overflow(a_ovf), .underflow(a_udf), .err_clr(a_err_clr)
    );

    data_fifo_flags #(.DATA_W(8), .DEPTH(4), .PTR_W(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .level(b_level),
        .overflow(b_ovf), .underflow(b_udf), .err_clr(b_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp3 [4];

    initial begin
        a_rst = 1; a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_err_clr = 0; a_wr_data = '0;
        b_rst = 1; b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_err_clr = 0; b_wr_data = '0;
        tick(); tick();
        a_rst = 0; b_rst = 0;

        // Reset state
        chk("rst_level", a_level, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_rdv", a_rd_valid, 0);
        chk("rst_rdata", a_rd_data, 0);
        chk("rst_b_empty", b_empty, 1);
        chk("rst_b_rdv", b_rd_valid, 0);

        // Fill to full, thresholds along the way
        a_wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_data = 8'hA1 + 8'(i);
            tick();
            chk("fill_level", a_level, i + 1);
            chk("fill_ae", a_ae, (i + 1 <= 1) ? 1 : 0);
            chk("fill_af", a_af, (i + 1 >= 3) ? 1 : 0);
        end
        chk("fill_full", a_full, 1);
        a_wr_data = 8'hA5;
        tick();
        chk("ovf_set", a_ovf, 1);
        chk("ovf_level", a_level, 4);
        a_wr_en = 0; a_err_clr = 1;
        tick();
        chk("ovf_clr", a_ovf, 0);
        a_err_clr = 0;

        // Drain in order with one-cycle valid pulses
        a_rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_data", a_rd_data, 8'hA1 + 8'(i));
            chk("drain_rdv", a_rd_valid, 1);
            chk("drain_level", a_level, 3 - i);
        end
        a_rd_en = 0;
        tick();
        chk("drain_rdv_low", a_rd_valid, 0);
        chk("drain_empty", a_empty, 1);
        chk("drain_hold", a_rd_data, 8'hA4);

        // Read+write on empty: read refused, write taken
        a_rd_en = 1; a_wr_en = 1; a_wr_data = 8'h55;
        tick();
        chk("udf_set", a_udf, 1);
        chk("udf_level", a_level, 1);
        chk("udf_rdv", a_rd_valid, 0);
        a_wr_en = 0;
        tick();
        chk("udf_data", a_rd_data, 8'h55);
        chk("udf_rdv2", a_rd_valid, 1);
        chk("udf_empty", a_empty, 1);
        a_err_clr = 1;
        tick();
        chk("set_wins", a_udf, 1);
        a_rd_en = 0;
        tick();
        chk("udf_clr", a_udf, 0);
        a_err_clr = 0;

        // Simultaneous write+read while full
        a_wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_data = 8'h11 + 8'(i);
            tick();
        end
        a_wr_data = 8'hB0; a_rd_en = 1;
        tick();
        chk("fullrw_level", a_level, 4);
        chk("fullrw_ovf", a_ovf, 0);
        chk("fullrw_data", a_rd_data, 8'h11);
        a_wr_en = 0;
        exp3[0] = 8'h12; exp3[1] = 8'h13; exp3[2] = 8'h14; exp3[3] = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fullrw_drain", a_rd_data, 32'(exp3[i]));
        end
        a_rd_en = 0;
        tick();
        chk("fullrw_empty", a_empty, 1);

        // Wrap-around streaming at fill 2
        a_wr_en = 1;
        a_wr_data = 8'h40; tick();
        a_wr_data = 8'h41; tick();
        a_rd_en = 1;
        for (int i = 0; i < 10; i++) begin
            a_wr_data = 8'h42 + 8'(i);
            tick();
            chk("wrap_data", a_rd_data, 8'h40 + 8'(i));
            chk("wrap_level", a_level, 2);
        end
        a_wr_en = 0;
        tick();
        chk("wrap_tail0", a_rd_data, 8'h4A);
        tick();
        chk("wrap_tail1", a_rd_data, 8'h4B);
        a_rd_en = 0;
        tick();
        chk("wrap_empty", a_empty, 1);

        // Flush at full with a concurrent write
        a_wr_en = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_data = 8'h60 + 8'(i);
            tick();
        end
        chk("pre_flush_full", a_full, 1);
        a_flush = 1; a_wr_data = 8'h99;
        tick();
        a_flush = 0; a_wr_en = 0;
        chk("flush_level", a_level, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ovf", a_ovf, 0);
        chk("flush_rdv", a_rd_valid, 0);
        chk("flush_ae", a_ae, 1);
        chk("flush_af", a_af, 0);
        chk("flush_hold", a_rd_data, 8'h4B);

        // FWFT instance
        b_wr_en = 1; b_wr_data = 8'hC1;
        tick();
        b_wr_en = 0;
        chk("fwft_data", b_rd_data, 8'hC1);
        chk("fwft_rdv", b_rd_valid, 1);
        chk("fwft_level", b_level, 1);
        b_wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            b_wr_data = 8'hC2 + 8'(i);
            tick();
        end
        chk("fwft_head", b_rd_data, 8'hC1);
        chk("fwft_full", b_full, 1);
        b_wr_data = 8'hC5;
        tick();
        chk("fwft_ovf", b_ovf, 1);
        b_wr_en = 0; b_err_clr = 1;
        tick();
        chk("fwft_ovf_clr", b_ovf, 0);
        b_err_clr = 0; b_rd_en = 1;
        tick();
        b_rd_en = 0;
        chk("fwft_pop", b_rd_data, 8'hC2);
        chk("fwft_pop_level", b_level, 3);
        b_rst = 1;
        tick();
        b_rst = 0;
        chk("frst_level", b_level, 0);
        chk("frst_empty", b_empty, 1);
        chk("frst_rdv", b_rd_valid, 0);
        chk("frst_ovf", b_ovf, 0);
        chk("frst_udf", b_udf, 0);
        b_wr_en = 1; b_wr_data = 8'hD0;
        tick();
        b_wr_en = 0;
        chk("frst_new", b_rd_data, 8'hD0);
        chk("frst_new_rdv", b_rd_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
